// File: rtl/motor_step_master.sv
// rtl/motor_step_master.sv - Avalon-MM master that sequences stepper coil patterns into a PIO data register
module motor_step_master #(
    parameter int PERIOD_W = 24,
    parameter int STEPS_W  = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                dir,
    input  logic                half_step,
    input  logic [STEPS_W-1:0]  steps,
    input  logic [PERIOD_W-1:0] period,
    input  logic                abort,
    output logic [1:0]          avm_address,
    output logic                avm_chipselect,
    output logic                avm_write_n,
    output logic [31:0]         avm_writedata,
    input  logic                avm_waitrequest,
    output logic                busy,
    output logic                done,
    output logic [STEPS_W-1:0]  position
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    logic [2:0]          r_phase;
    logic [STEPS_W-1:0]  r_pos;
    logic [STEPS_W-1:0]  r_remain;
    logic [PERIOD_W-1:0] r_period;
    logic                r_dir;
    logic                r_half;
    logic                r_abort_pend;
    logic [PERIOD_W-1:0] r_wait_cnt;
    logic [3:0]          r_wdata;
    logic                r_cs;
    logic                r_wr_n;
    logic                r_busy;
    logic                r_done;

    state_t              w_state_nxt;
    logic [2:0]          w_phase_nxt;
    logic [STEPS_W-1:0]  w_pos_nxt;
    logic [STEPS_W-1:0]  w_remain_nxt;
    logic [PERIOD_W-1:0] w_period_nxt;
    logic                w_dir_nxt;
    logic                w_half_nxt;
    logic                w_abort_nxt;
    logic [PERIOD_W-1:0] w_wait_nxt;
    logic [3:0]          w_wdata_nxt;
    logic                w_enter_write;
    logic                w_dir_use;
    logic                w_half_use;
    logic [PERIOD_W-1:0] w_period_eff;

    // Full-step mode snaps to the even (single-coil) entries before moving by two.
    function automatic logic [2:0] f_next_phase(input logic [2:0] ph, input logic d, input logic h);
        logic [2:0] base;
        base = {ph[2:1], 1'b0};
        if (h) begin
            return d ? (ph - 3'd1) : (ph + 3'd1);
        end
        return d ? (base - 3'd2) : (base + 3'd2);
    endfunction

    function automatic logic [3:0] f_coil(input logic [2:0] idx);
        case (idx)
            3'd0:    return 4'b0001;
            3'd1:    return 4'b0011;
            3'd2:    return 4'b0010;
            3'd3:    return 4'b0110;
            3'd4:    return 4'b0100;
            3'd5:    return 4'b1100;
            3'd6:    return 4'b1000;
            default: return 4'b1001;
        endcase
    endfunction

    assign w_period_eff = (r_period == '0) ? PERIOD_W'(1) : r_period;

    // Next-state and next-register values for the command sequencer.
    always_comb begin
        w_state_nxt   = r_state;
        w_phase_nxt   = r_phase;
        w_pos_nxt     = r_pos;
        w_remain_nxt  = r_remain;
        w_period_nxt  = r_period;
        w_dir_nxt     = r_dir;
        w_half_nxt    = r_half;
        w_abort_nxt   = r_abort_pend;
        w_wait_nxt    = r_wait_cnt;
        w_wdata_nxt   = r_wdata;
        w_enter_write = 1'b0;
        w_dir_use     = r_dir;
        w_half_use    = r_half;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_dir_nxt    = dir;
                    w_half_nxt   = half_step;
                    w_remain_nxt = steps;
                    w_period_nxt = period;
                    w_abort_nxt  = 1'b0;
                    if (steps != '0) begin
                        w_state_nxt   = S_WRITE;
                        w_enter_write = 1'b1;
                        w_dir_use     = dir;
                        w_half_use    = half_step;
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_WRITE: begin
                if (abort) begin
                    w_abort_nxt = 1'b1;
                end
                if (!avm_waitrequest) begin
                    w_pos_nxt    = r_dir ? (r_pos - STEPS_W'(1)) : (r_pos + STEPS_W'(1));
                    w_remain_nxt = r_remain - STEPS_W'(1);
                    if ((r_remain == STEPS_W'(1)) || abort || r_abort_pend) begin
                        w_state_nxt = S_DONE;
                        w_abort_nxt = 1'b0;
                    end else if (w_period_eff == PERIOD_W'(1)) begin
                        // Back-to-back writes: re-enter WRITE with the next pattern.
                        w_enter_write = 1'b1;
                    end else begin
                        w_state_nxt = S_WAIT;
                        w_wait_nxt  = w_period_eff - PERIOD_W'(2);
                    end
                end
            end
            S_WAIT: begin
                if (abort) begin
                    w_state_nxt = S_DONE;
                end else if (r_wait_cnt == '0) begin
                    w_state_nxt   = S_WRITE;
                    w_enter_write = 1'b1;
                end else begin
                    w_wait_nxt = r_wait_cnt - PERIOD_W'(1);
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_enter_write) begin
            w_phase_nxt = f_next_phase(r_phase, w_dir_use, w_half_use);
            w_wdata_nxt = f_coil(w_phase_nxt);
        end
    end

    // State register plus registered bus and status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_phase      <= 3'd0;
            r_pos        <= '0;
            r_remain     <= '0;
            r_period     <= '0;
            r_dir        <= 1'b0;
            r_half       <= 1'b0;
            r_abort_pend <= 1'b0;
            r_wait_cnt   <= '0;
            r_wdata      <= 4'd0;
            r_cs         <= 1'b0;
            r_wr_n       <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_phase      <= w_phase_nxt;
            r_pos        <= w_pos_nxt;
            r_remain     <= w_remain_nxt;
            r_period     <= w_period_nxt;
            r_dir        <= w_dir_nxt;
            r_half       <= w_half_nxt;
            r_abort_pend <= w_abort_nxt;
            r_wait_cnt   <= w_wait_nxt;
            r_wdata      <= w_wdata_nxt;
            r_cs         <= (w_state_nxt == S_WRITE);
            r_wr_n       <= (w_state_nxt != S_WRITE);
            r_busy       <= (w_state_nxt == S_WRITE) || (w_state_nxt == S_WAIT);
            r_done       <= (w_state_nxt == S_DONE);
        end
    end

    assign avm_address    = 2'b00;
    assign avm_chipselect = r_cs;
    assign avm_write_n    = r_wr_n;
    assign avm_writedata  = {28'd0, r_wdata};
    assign busy           = r_busy;
    assign done           = r_done;
    assign position       = r_pos;

endmodule

// File: tb/tb_motor_step_master.sv
// tb/tb_motor_step_master.sv - self-checking bench for motor_step_master
module tb_motor_step_master;

    localparam int N = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        dir = 1'b0;
    logic        half_step = 1'b0;
    logic [15:0] steps = 16'd0;
    logic [23:0] period = 24'd0;
    logic        abort = 1'b0;
    logic [1:0]  avm_address;
    logic        avm_chipselect;
    logic        avm_write_n;
    logic [31:0] avm_writedata;
    logic        avm_waitrequest = 1'b0;
    logic        busy;
    logic        done;
    logic [15:0] position;

    int checks = 0;
    int errors = 0;

    logic [3:0]  coil [0:7] = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h4, 4'hC, 4'h8, 4'h9};
    bit          exp_cs   [0:N-1];
    logic [3:0]  exp_data [0:N-1];
    bit          exp_busy [0:N-1];
    bit          exp_done [0:N-1];
    logic [15:0] exp_pos  [0:N-1];
    bit          drv_wreq [0:N-1];
    int          m_phase = 0;
    logic [15:0] m_pos = 16'd0;

    bit          chk_en = 1'b0;
    int          cur = 0;
    int          got_n = 0;
    int          got_cyc [0:15];
    logic [3:0]  got_dat [0:15];
    int          last_done = -1;

    motor_step_master #(.PERIOD_W(24), .STEPS_W(16)) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .dir             (dir),
        .half_step       (half_step),
        .steps           (steps),
        .period          (period),
        .abort           (abort),
        .avm_address     (avm_address),
        .avm_chipselect  (avm_chipselect),
        .avm_write_n     (avm_write_n),
        .avm_writedata   (avm_writedata),
        .avm_waitrequest (avm_waitrequest),
        .busy            (busy),
        .done            (done),
        .position        (position)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks = checks + 1;
        if (act !== req) begin
            errors = errors + 1;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", nm, cur, act, req);
        end
    endtask

    // Builds the expected per-cycle picture of one command from the write schedule:
    // write k asserted at t_k, accepted after its stalls, next write P cycles after acceptance.
    task automatic build_model(input bit d, input bit h, input int st, input int per,
                               input int stall0, input int ab);
        int  p;
        int  t;
        int  a;
        bit  ended;
        p = (per == 0) ? 1 : per;
        for (int c = 0; c < N; c++) begin
            exp_cs[c] = 1'b0; exp_data[c] = 4'd0; exp_busy[c] = 1'b0;
            exp_done[c] = 1'b0; exp_pos[c] = m_pos; drv_wreq[c] = 1'b0;
        end
        if (st == 0) begin
            exp_done[1] = 1'b1;
            return;
        end
        t = 1;
        ended = 1'b0;
        for (int k = 0; k < st && !ended; k++) begin
            if (h) m_phase = (m_phase + (d ? 7 : 1)) % 8;
            else   m_phase = ((m_phase / 2) * 2 + (d ? 6 : 2)) % 8;
            a = t + ((k == 0) ? stall0 : 0);
            for (int c = t; c <= a; c++) begin
                exp_cs[c] = 1'b1; exp_data[c] = coil[m_phase]; exp_busy[c] = 1'b1;
                drv_wreq[c] = (c < a);
            end
            m_pos = d ? (m_pos - 16'd1) : (m_pos + 16'd1);
            for (int c = a + 1; c < N; c++) exp_pos[c] = m_pos;
            if (k == st - 1 || (ab >= t && ab <= a)) begin
                exp_done[a + 1] = 1'b1;
                ended = 1'b1;
            end else begin
                for (int c = a + 1; c <= a + p - 1 && !ended; c++) begin
                    exp_busy[c] = 1'b1;
                    if (ab == c) begin
                        exp_done[c + 1] = 1'b1;
                        ended = 1'b1;
                    end
                end
                t = a + p;
            end
        end
    endtask

    task automatic run_cmd(input bit d, input bit h, input int st, input int per,
                           input int stall0, input int ab, input int restart, input int ncyc);
        build_model(d, h, st, per, stall0, ab);
        got_n = 0;
        last_done = -1;
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk); #1;
            cur = c;
            chk_en = 1'b1;
            start = (c == 0) || (c == restart);
            dir = d;
            half_step = h;
            steps = (c == 0) ? 16'(st) : 16'(st + 5);
            period = 24'(per);
            abort = (c == ab);
            avm_waitrequest = drv_wreq[c];
        end
        @(posedge clk); #1;
        chk_en = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        avm_waitrequest = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        m_phase = 0;
        m_pos = 16'd0;
    endtask

    // Per-cycle comparison of every DUT output against the model, mid-cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("chipselect", {31'd0, avm_chipselect}, {31'd0, exp_cs[cur]});
            chk("write_n", {31'd0, avm_write_n}, {31'd0, !exp_cs[cur]});
            chk("address", {30'd0, avm_address}, 32'd0);
            chk("busy", {31'd0, busy}, {31'd0, exp_busy[cur]});
            chk("done", {31'd0, done}, {31'd0, exp_done[cur]});
            chk("position", {16'd0, position}, {16'd0, exp_pos[cur]});
            if (exp_cs[cur]) chk("writedata", avm_writedata, {28'd0, exp_data[cur]});
            if (avm_chipselect && !avm_waitrequest && got_n < 16) begin
                got_cyc[got_n] = cur;
                got_dat[got_n] = avm_writedata[3:0];
                got_n = got_n + 1;
            end
            if (done) last_done = cur;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset defaults
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_cs", {31'd0, avm_chipselect}, 32'd0);
        chk("rst_write_n", {31'd0, avm_write_n}, 32'd1);
        chk("rst_addr", {30'd0, avm_address}, 32'd0);
        chk("rst_data", avm_writedata, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_pos", {16'd0, position}, 32'd0);

        // Forward full-step
        run_cmd(1'b0, 1'b0, 3, 4, 0, -1, -1, 14);
        chk("fwd_nwrites", got_n, 3);
        chk("fwd_w0_cyc", got_cyc[0], 1);
        chk("fwd_w0_dat", {28'd0, got_dat[0]}, 32'h2);
        chk("fwd_w1_cyc", got_cyc[1], 5);
        chk("fwd_w1_dat", {28'd0, got_dat[1]}, 32'h4);
        chk("fwd_w2_cyc", got_cyc[2], 9);
        chk("fwd_w2_dat", {28'd0, got_dat[2]}, 32'h8);
        chk("fwd_done_cyc", last_done, 10);
        chk("fwd_pos", {16'd0, position}, 32'd3);

        // Reverse half-step with wrap
        do_reset();
        run_cmd(1'b1, 1'b1, 2, 2, 0, -1, -1, 8);
        chk("rev_w0_dat", {28'd0, got_dat[0]}, 32'h9);
        chk("rev_w1_dat", {28'd0, got_dat[1]}, 32'h8);
        chk("rev_pos", {16'd0, position}, 32'hFFFE);

        // Stall on the first write
        do_reset();
        run_cmd(1'b0, 1'b1, 2, 4, 3, -1, -1, 12);
        chk("stall_acc0_cyc", got_cyc[0], 4);
        chk("stall_acc1_cyc", got_cyc[1], 8);
        chk("stall_w0_dat", {28'd0, got_dat[0]}, 32'h3);

        // Abort during the second write
        do_reset();
        run_cmd(1'b0, 1'b0, 10, 3, 0, 4, -1, 9);
        chk("abw_nwrites", got_n, 2);
        chk("abw_done_cyc", last_done, 5);
        chk("abw_pos", {16'd0, position}, 32'd2);

        // Abort during WAIT, half-step leaves the phase odd
        run_cmd(1'b0, 1'b1, 10, 4, 0, 3, -1, 8);
        chk("abwait_nwrites", got_n, 1);
        chk("abwait_dat", {28'd0, got_dat[0]}, 32'hC);
        chk("abwait_done_cyc", last_done, 4);

        // Zero steps
        run_cmd(1'b0, 1'b0, 0, 4, 0, -1, -1, 4);
        chk("zero_nwrites", got_n, 0);
        chk("zero_done_cyc", last_done, 1);

        // Period 0 full-step from odd phase, with a start while busy
        run_cmd(1'b0, 1'b0, 4, 0, 0, -1, 2, 8);
        chk("p0_nwrites", got_n, 4);
        chk("p0_w0_dat", {28'd0, got_dat[0]}, 32'h8);
        chk("p0_w3_cyc", got_cyc[3], 4);
        chk("p0_done_cyc", last_done, 5);
        chk("p0_pos", {16'd0, position}, 32'd7);

        // Reset during WAIT
        @(posedge clk); #1;
        cur = 0;
        start = 1'b1; dir = 1'b0; half_step = 1'b0; steps = 16'd5; period = 24'd6;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rw_pre_busy", {31'd0, busy}, 32'd1);
        chk("rw_pre_pos", {16'd0, position}, 32'd8);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rw_cs", {31'd0, avm_chipselect}, 32'd0);
        chk("rw_write_n", {31'd0, avm_write_n}, 32'd1);
        chk("rw_busy", {31'd0, busy}, 32'd0);
        chk("rw_done", {31'd0, done}, 32'd0);
        chk("rw_pos", {16'd0, position}, 32'd0);
        m_phase = 0;
        m_pos = 16'd0;
        run_cmd(1'b0, 1'b0, 1, 1, 0, -1, -1, 4);
        chk("rw_after_dat", {28'd0, got_dat[0]}, 32'h2);
        chk("rw_after_pos", {16'd0, position}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
